// File: rtl/down_counter_if.sv
// Control and status bundle for down_counter: the bench drives the strobes
// and the counter drives the count and its flags.
interface down_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             load;
  logic             oneshot;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             borrow;
  logic             done;

  modport master (
    output en, load, oneshot, load_val,
    input  count, zero, borrow, done
  );

  modport slave (
    input  en, load, oneshot, load_val,
    output count, zero, borrow, done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with free-running wrap mode and stop-at-zero (HALT) mode.
// The count, borrow pulse and HALT state are all registered.
module down_counter #(
  parameter int WIDTH = 3
) (
  input  logic           clk,
  input  logic           rst,
  down_counter_if.slave  bus
);

  localparam logic [0:0] S_COUNT = 1'b0;
  localparam logic [0:0] S_HALT  = 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic             borrow_q, borrow_d;

  // Priority is load, then enable, then hold. oneshot only matters at an enabled zero.
  always_comb begin
    count_d  = count_q;
    state_d  = state_q;
    borrow_d = 1'b0;
    if (bus.load) begin
      count_d = bus.load_val;
      state_d = S_COUNT;
    end else if (state_q == S_COUNT && bus.en) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else if (!bus.oneshot) begin
        count_d  = '1;
        borrow_d = 1'b1;
      end else begin
        state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      state_q  <= S_COUNT;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      state_q  <= state_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.zero   = (count_q == '0);
  assign bus.borrow = borrow_q;
  assign bus.done   = (state_q == S_HALT);

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: directed vector table and reset sequences on a 3-bit
// instance, then random traffic on 3-bit and 8-bit instances against a model.
module tb_down_counter;

  logic clk;
  logic rst;

  down_counter_if #(.WIDTH(3)) if3 ();
  down_counter_if #(.WIDTH(8)) if8 ();

  down_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  down_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    bit       load;
    bit       en;
    bit       oneshot;
    int       load_val;
    int       exp_count;
    bit       exp_borrow;
    bit       exp_done;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit l, input bit e, input bit o, input int lv,
                     input int c, input bit b, input bit d);
    vecs[n_vec] = '{load: l, en: e, oneshot: o, load_val: lv,
                    exp_count: c, exp_borrow: b, exp_done: d};
    n_vec++;
  endtask

  task automatic drive3(input bit l, input bit e, input bit o, input int lv);
    if3.load     = l;
    if3.en       = e;
    if3.oneshot  = o;
    if3.load_val = 3'(lv);
  endtask

  task automatic check3(input string tag, input int c, input bit b, input bit d);
    chk({tag, ".count"},  int'(if3.count),  c);
    chk({tag, ".zero"},   int'(if3.zero),   int'(c == 0));
    chk({tag, ".borrow"}, int'(if3.borrow), int'(b));
    chk({tag, ".done"},   int'(if3.done),   int'(d));
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_step(input int w, input bit l, input bit e, input bit o,
                            input int lv, inout int c, inout bit h, output bit b);
    b = 1'b0;
    if (l) begin
      c = lv;
      h = 1'b0;
    end else if (!h && e) begin
      if (c != 0)  c = c - 1;
      else if (!o) begin
        c = (1 << w) - 1;
        b = 1'b1;
      end else h = 1'b1;
    end
  endtask

  int m3_c, m8_c;
  bit m3_h, m8_h, m3_b, m8_b;
  bit p3_b, p8_b;

  initial begin
    drive3(0, 0, 0, 0);
    if8.load = 0; if8.en = 0; if8.oneshot = 0; if8.load_val = '0;
    rst = 1'b0;

    // Free-running wrap from reset
    for (int i = 0; i < 10; i++)
      add(0, 1, 0, 0, (8 - 1 - i) & 7, (i == 0) || (i == 8), 0);
    // One-shot run down to HALT
    add(1, 0, 1, 5, 5, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 1, 0, (i < 4) ? 4 - i : 0, 0, i >= 5);
    // HALT ignores en and oneshot, load releases it
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 3, 3, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1);
    add(1, 1, 0, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 7, 1, 0);
    add(0, 0, 0, 0, 7, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check3("reset", 0, 0, 0);
    drive3(1, 1, 0, 6);
    @(posedge clk); #1;
    check3("reset_ignores_inputs", 0, 0, 0);
    drive3(0, 1, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      drive3(vecs[i].load, vecs[i].en, vecs[i].oneshot, vecs[i].load_val);
      @(posedge clk); #1;
      check3($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_borrow, vecs[i].exp_done);
    end

    // Asynchronous reset mid-cycle while count is 4, then resume from 0
    drive3(1, 0, 0, 4);
    @(posedge clk); #1;
    check3("preload4", 4, 0, 0);
    drive3(0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 check3("async_rst", 0, 0, 0);
    #1 rst = 1'b1;
    drive3(0, 1, 0, 0);
    @(posedge clk); #1;
    check3("resume_wrap", 7, 1, 0);
    @(posedge clk); #1;
    check3("resume_dec", 6, 0, 0);

    // Reset kills a pending borrow
    drive3(1, 0, 0, 0);
    @(posedge clk); #1;
    drive3(0, 1, 0, 0);
    @(posedge clk); #1;
    check3("borrow_before_rst", 7, 1, 0);
    rst = 1'b0;
    #1 check3("rst_clears_borrow", 0, 0, 0);
    #1 rst = 1'b1;

    // Reset aborts HALT
    drive3(1, 0, 1, 0);
    @(posedge clk); #1;
    drive3(0, 1, 1, 0);
    @(posedge clk); #1;
    check3("halt_before_rst", 0, 0, 1);
    rst = 1'b0;
    #1 check3("rst_clears_halt", 0, 0, 0);
    #1 rst = 1'b1;

    // Random traffic on both widths
    p3_b = 0; p8_b = 0;
    for (int i = 0; i < 2000; i++) begin
      bit l3, e3, o3, l8, e8, o8;
      int v3, v8;
      l3 = (i == 0) || ($urandom_range(7) == 0);
      l8 = (i == 0) || ($urandom_range(15) == 0);
      e3 = $urandom_range(3) != 0;
      e8 = $urandom_range(3) != 0;
      o3 = $urandom_range(3) == 0;
      o8 = $urandom_range(3) == 0;
      v3 = int'($urandom_range(7));
      v8 = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : int'($urandom_range(255));
      drive3(l3, e3, o3, v3);
      if8.load = l8; if8.en = e8; if8.oneshot = o8; if8.load_val = 8'(v8);
      @(posedge clk); #1;
      model_step(3, l3, e3, o3, v3, m3_c, m3_h, m3_b);
      model_step(8, l8, e8, o8, v8, m8_c, m8_h, m8_b);
      chk("rnd3.count",  int'(if3.count),  m3_c);
      chk("rnd3.zero",   int'(if3.zero),   int'(m3_c == 0));
      chk("rnd3.borrow", int'(if3.borrow), int'(m3_b));
      chk("rnd3.done",   int'(if3.done),   int'(m3_h));
      chk("rnd8.count",  int'(if8.count),  m8_c);
      chk("rnd8.zero",   int'(if8.zero),   int'(m8_c == 0));
      chk("rnd8.borrow", int'(if8.borrow), int'(m8_b));
      chk("rnd8.done",   int'(if8.done),   int'(m8_h));
      chk("rnd3.borrow_twice", int'(p3_b && if3.borrow), 0);
      chk("rnd8.borrow_twice", int'(p8_b && if8.borrow), 0);
      p3_b = if3.borrow;
      p8_b = if8.borrow;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
